// File: rtl/opc2_io_pkg.sv
// Shared definitions for the opc2 memory-mapped I/O blocks.
package opc2_io_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Register offset within the two-byte window (address bit 0).
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS byte bit positions.
  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF    = 3;

endpackage

// File: rtl/opc2_fifo.sv
// Small synchronous FIFO with show-ahead output. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module opc2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rptr];

  // Storage array; not reset, contents are only visible through count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opc2_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the opc2 bus.
//
// state    | meaning
// ---------+-----------------------------------------------
// TX_IDLE  | line high, waiting for a byte in the FIFO
// TX_START | start bit (low) for CLK_DIV cycles
// TX_DATA  | eight data bits, LSB first, CLK_DIV cycles each
// TX_STOP  | stop bit (high); chains to next byte if queued
module opc2_uart_tx
  import opc2_io_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR  = 10'h3FE,
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] address,
  input  logic       rnw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       sel,
  output logic       txd,
  output logic       busy
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BCNT_MAX = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BCNT_ONE = BW'(1);

  tx_state_t  state, state_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic [2:0] bidx, bidx_d;
  logic [7:0] shift, shift_d;
  logic       txd_d;
  logic       bit_end;

  logic       data_wr, status_rd, overflow, ovf;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [7:0] status;

  assign sel       = (address[9:1] == BASE_ADDR[9:1]);
  assign data_wr   = sel & ~rnw & (address[0] == REG_DATA);
  assign status_rd = sel &  rnw & (address[0] == REG_STATUS);
  assign overflow  = data_wr & fifo_full & ~fifo_pop;
  assign busy      = (state != TX_IDLE) || (fifo_count != '0);
  assign bit_end   = (bcnt == BCNT_MAX);

  opc2_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .pop   (fifo_pop),
    .din   (wdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow flag; a same-cycle overflow beats the read-clear.
  always_ff @(posedge clk) begin
    if (reset)          ovf <= 1'b0;
    else if (overflow)  ovf <= 1'b1;
    else if (status_rd) ovf <= 1'b0;
  end

  // Serialiser state and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TX_IDLE;
      bcnt  <= '0;
      bidx  <= '0;
      shift <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_d;
      bcnt  <= bcnt_d;
      bidx  <= bidx_d;
      shift <= shift_d;
      txd   <= txd_d;
    end
  end

  // Next-state logic; txd is derived from the next state so it is glitch-free.
  always_comb begin
    state_d  = state;
    bcnt_d   = bcnt;
    bidx_d   = bidx;
    shift_d  = shift;
    fifo_pop = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bcnt_d   = '0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          bcnt_d  = '0;
          bidx_d  = '0;
          state_d = TX_DATA;
        end else begin
          bcnt_d = bcnt + BCNT_ONE;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          bcnt_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          if (bidx == 3'd7) state_d = TX_STOP;
          else              bidx_d  = bidx + 3'd1;
        end else begin
          bcnt_d = bcnt + BCNT_ONE;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          bcnt_d = bcnt + BCNT_ONE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // Read mux: STATUS returns flags, DATA and unselected addresses read zero.
  always_comb begin
    status            = '0;
    status[ST_FULL]   = fifo_full;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_ACTIVE] = (state != TX_IDLE);
    status[ST_OVF]    = ovf;
    rdata = 8'h00;
    if (sel && (address[0] == REG_STATUS)) rdata = status;
  end

endmodule

// File: tb/tb_opc2_uart_tx.sv
// Self-checking bench for opc2_uart_tx: frame-timeline model plus directed tests.
module tb_opc2_uart_tx;

  localparam int D     = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] address = 10'h000;
  logic       rnw = 1'b1;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       sel, txd, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  opc2_uart_tx #(.BASE_ADDR(10'h3FE), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .rnw(rnw),
    .wdata(wdata), .rdata(rdata), .sel(sel), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a FIFO queue plus the position within the current frame.
  logic [7:0] mq[$];
  bit         m_inframe = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;
  int         m_frames = 0;
  logic       m_txd = 1'b1;

  always @(posedge clk) begin
    bit req, st_rd, pop, ovfl;
    logic [7:0] popped;
    int k;
    if (reset) begin
      mq.delete();
      m_inframe = 1'b0;
      m_t = 0;
      m_ovf = 1'b0;
      m_txd = 1'b1;
    end else begin
      req   = (address == 10'h3FE) && !rnw;
      st_rd = (address == 10'h3FF) && rnw;
      pop   = (mq.size() > 0) && (!m_inframe || m_t == FRAME - 1);
      popped = 8'h00;
      if (pop) popped = mq.pop_front();
      ovfl = 1'b0;
      if (req) begin
        if (mq.size() < DEPTH) mq.push_back(wdata);
        else ovfl = 1'b1;
      end
      if (ovfl) m_ovf = 1'b1;
      else if (st_rd) m_ovf = 1'b0;
      if (pop) begin
        m_inframe = 1'b1;
        m_t = 0;
        m_byte = popped;
        m_frames++;
      end else if (m_inframe) begin
        if (m_t == FRAME - 1) m_inframe = 1'b0;
        else m_t++;
      end
      if (!m_inframe) m_txd = 1'b1;
      else begin
        k = m_t / D;
        if (k == 0)      m_txd = 1'b0;
        else if (k == 9) m_txd = 1'b1;
        else             m_txd = m_byte[k-1];
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    logic [7:0] st;
    logic       esel;
    if (cyc > 0) begin
      st   = {4'b0, m_ovf, m_inframe, (mq.size() == 0), (mq.size() == DEPTH)};
      esel = (address[9:1] == 9'h1FF);
      chk("txd", txd, m_txd);
      chk("busy", busy, m_inframe || (mq.size() != 0));
      chk("sel", sel, esel);
      chk("rdata", rdata, (esel && address[0]) ? st : 8'h00);
    end
  end

  task automatic bus_idle();
    address = 10'h000;
    rnw = 1'b1;
    wdata = 8'h00;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    address = a;
    rnw = 1'b0;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  initial begin
    int k, f0;
    logic [9:0]  a5_line;
    logic [19:0] bb_line;
    a5_line = 10'b1101001010;
    bb_line = {10'b1000011110, 10'b1010101010};

    // Reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    address = 10'h3FF;
    @(negedge clk);
    chk("rst_status", rdata, 8'h02);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    bus_idle();
    repeat (3) @(posedge clk);
    #1;

    // Single byte A5
    wr(10'h3FE, 8'hA5);
    k = cyc;
    bus_idle();
    @(negedge clk);
    chk("a5_pre_start", txd, 1'b1);
    chk("a5_busy_k", busy, 1'b1);
    wait_cyc(k + 1);
    chk("a5_start_edge", txd, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wait_cyc(k + 1 + D*i + D/2);
      chk("a5_bit", txd, a5_line[i]);
    end
    wait_cyc(k + FRAME);
    chk("a5_busy_end", busy, 1'b1);
    wait_cyc(k + FRAME + 1);
    chk("a5_busy_fall", busy, 1'b0);
    chk("a5_idle_txd", txd, 1'b1);

    // Back-to-back 55, 0F
    wr(10'h3FE, 8'h55);
    k = cyc;
    wr(10'h3FE, 8'h0F);
    bus_idle();
    for (int i = 0; i < 20; i++) begin
      wait_cyc(k + 1 + D*i + D/2);
      chk("b2b_bit", txd, bb_line[i]);
    end
    wait_cyc(k + 2*FRAME);
    chk("b2b_busy_end", busy, 1'b1);
    wait_cyc(k + 2*FRAME + 1);
    chk("b2b_busy_fall", busy, 1'b0);

    // Overflow: six consecutive writes, the sixth is dropped
    f0 = m_frames;
    wr(10'h3FE, 8'h11);
    k = cyc;
    wr(10'h3FE, 8'h22);
    wr(10'h3FE, 8'h33);
    wr(10'h3FE, 8'h44);
    wr(10'h3FE, 8'h55);
    wr(10'h3FE, 8'h66);
    address = 10'h3FF;
    rnw = 1'b1;
    @(negedge clk);
    chk("ovf_status", rdata, 8'h0D);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovf_cleared", rdata, 8'h05);
    bus_idle();
    wait_cyc(k + 5*FRAME);
    chk("ovf_busy_end", busy, 1'b1);
    wait_cyc(k + 5*FRAME + 1);
    chk("ovf_busy_fall", busy, 1'b0);
    chk("ovf_frames", m_frames - f0, 5);

    // Reset during data bit 3 with two bytes queued
    f0 = m_frames;
    wr(10'h3FE, 8'hA1);
    k = cyc;
    wr(10'h3FE, 8'hB2);
    wr(10'h3FE, 8'hC3);
    bus_idle();
    wait_cyc(k + 1 + 4*D + 5);
    chk("rst_mid_bit3", txd, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    address = 10'h3FF;
    @(negedge clk);
    chk("rst_mid_txd", txd, 1'b1);
    chk("rst_mid_status", rdata, 8'h02);
    chk("rst_mid_busy", busy, 1'b0);
    bus_idle();
    wait_cyc(cyc + 3*FRAME);
    chk("rst_mid_quiet", txd, 1'b1);
    chk("rst_mid_frames", m_frames - f0, 1);

    // Address decode
    wr(10'h3FD, 8'h77);
    wr(10'h000, 8'h88);
    bus_idle();
    @(negedge clk);
    chk("dec_000_sel", sel, 1'b0);
    chk("dec_000_rdata", rdata, 8'h00);
    address = 10'h3FD;
    @(negedge clk);
    chk("dec_3fd_sel", sel, 1'b0);
    chk("dec_3fd_rdata", rdata, 8'h00);
    address = 10'h3FE;
    @(negedge clk);
    chk("dec_data_sel", sel, 1'b1);
    chk("dec_data_rdata", rdata, 8'h00);
    address = 10'h3FF;
    @(negedge clk);
    chk("dec_status", rdata, 8'h02);
    chk("dec_busy", busy, 1'b0);
    bus_idle();
    repeat (4) @(negedge clk);
    chk("dec_txd", txd, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opc2_uart_tx.md
# opc2_uart_tx

Memory-mapped UART transmitter on the opc2 CPU bus, downstream of `opc2cpu`: it decodes two byte locations in the CPU's 10-bit address space, buffers bytes the CPU writes into a small FIFO and serialises them on `txd` as 8N1 frames. It sits beside the program RAM on the same `address`/`data`/`rnw` bus. The top level owns the tri-state `data` bus: it drives `rdata` onto `data` when `sel` is high and `rnw` is high.

## Interface
- `BASE_ADDR`, 10'h3FE: DATA register at BASE_ADDR, STATUS at BASE_ADDR+1 (BASE_ADDR even).
- `CLK_DIV`, 16: clocks per serial bit, ≥2.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 10: CPU address.
- `rnw` in 1: 1 = read, 0 = write.
- `wdata` in 8: CPU write data (bus `data`).
- `rdata` out 8: read data, combinational from `address`/state.
- `sel` out 1: `address` hits DATA or STATUS.
- `txd` out 1: serial output, idle high.
- `busy` out 1: serialiser not IDLE or FIFO non-empty.

## Operation
- Write strobe: `sel & !rnw` sampled each rising edge. A write held for N cycles pushes N times; the CPU holds a write for one cycle.
- Write to DATA:
  - Pushes `wdata` if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky `ovf` is set.
- Writes to STATUS are ignored.
- Read of STATUS returns the byte `{4'b0, ovf, active, empty, full}`:
  - bit0 `full`, bit1 `empty`, bit2 `active` (FSM not IDLE), bit3 `ovf`.
- A rising edge with `sel & rnw` at STATUS clears `ovf`. If an overflow happens in the same cycle, the set wins.
- Read of DATA returns 8'h00. When `sel`=0, `rdata` = 8'h00.
- Serialiser FSM, states IDLE, START, DATA, STOP; baud counter `bcnt` counts 0..CLK_DIV-1.
  - IDLE: `txd`=1. If the FIFO is non-empty: pop into shift register, `bcnt`←0, go to START.
  - START: `txd`=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: `txd`=shift[0], LSB first. Each bit lasts CLK_DIV cycles, then shift right. After bit 7 go to STOP.
  - STOP: `txd`=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.
- Frame length is exactly 10×CLK_DIV cycles.
- `txd` is registered. No glitch at state changes.
- FIFO count is held consistent under simultaneous push and pop: count unchanged, pointers both advance and wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `txd`=1, `busy`=0, FSM IDLE, `bcnt`=0, FIFO empty (`empty`=1, `full`=0), `ovf`=0, pointers 0. `rdata` and `sel` are combinational.
- Reset asserted mid-frame: on the next edge `txd`=1, FIFO is flushed, and the frame is abandoned.
- Push to empty FIFO with FSM IDLE:
  - The byte is in the FIFO after edge k.
  - The pop happens at edge k+1.
  - `txd` falls after edge k+1.
- `busy` is 1 from edge k onward, falling at the edge that returns the FSM to IDLE with the FIFO empty.
- STATUS `empty`/`full` reflect the post-edge count; there is no read latency.
- Bit boundaries fall every CLK_DIV edges from the START entry.

## Structure
- Package `opc2_io_pkg`:
  - FSM state enum (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`).
  - Register offsets (`REG_DATA`=0, `REG_STATUS`=1).
  - Status bit positions.
- Sub-module `opc2_fifo` (parameterised width/depth, push/pop/full/empty/count, synchronous active-high reset). The UART top instantiates it.

## Test plan
- Reset: hold `reset` 3 cycles. STATUS reads 8'h02, `txd`=1, `busy`=0.
- Single byte: write 8'hA5 to 10'h3FE.
  - `txd` falls one edge later.
  - Line carries 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - Total frame 160 cycles, then IDLE and `busy`=0.
- Back-to-back: write 8'h55, 8'h0F on consecutive cycles. The two frames are contiguous: second start bit immediately after the first stop bit, 320 cycles total.
- Overflow:
  - 6 writes in consecutive cycles. The first is popped immediately, then 4 fill the FIFO; the 6th is dropped.
  - STATUS reads 8'h0D (ovf, active, full).
  - Next STATUS read returns 8'h05.
  - Exactly 5 frames are emitted.
- Reset mid-frame: assert `reset` during bit 3 of a frame with 2 bytes queued. `txd`=1 next edge, STATUS 8'h02, no further frames.
- Decode: write to 10'h3FD and 10'h000. No push, `sel`=0, and `rdata`=8'h00 on reads there.
